// File: rtl/dsp_pkg.sv
// Shared constants for the DSP48A1-style datapath slices.
// Holds the operand widths, the pipeline depth limit and the input-select encoding.
package dsp_pkg;

    localparam int OPREG_DEPTH_MAX = 4;

    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int D_W = 18;
    localparam int C_W = 48;

    localparam logic SEL_DIRECT  = 1'b0;
    localparam logic SEL_CASCADE = 1'b1;

endpackage

// File: rtl/opreg_pipe_if.sv
// Operand pipeline bus: enable, input select, both operand sources and the outputs.
// The slave modport belongs to the pipe; the master side is whoever feeds and consumes it.
interface opreg_pipe_if #(
    parameter int WIDTH = 18
);
    logic             CE;
    logic             SEL_CASC;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] DCIN;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] DCOUT;
    logic             VALID;

    modport master (
        output CE, SEL_CASC, D, DCIN,
        input  Q, DCOUT, VALID
    );

    modport slave (
        input  CE, SEL_CASC, D, DCIN,
        output Q, DCOUT, VALID
    );
endinterface

// File: rtl/opreg_stage.sv
// One WIDTH-bit operand register with synchronous active-high reset and clock enable.
// Reset takes priority over enable.
module opreg_stage #(
    parameter int WIDTH = 18
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else if (CE) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/opreg_pipe.sv
// Parametrised operand input pipeline with direct/cascade input select and fill tracking.
// DEPTH=0 degenerates to a pure input mux with VALID tied high.
module opreg_pipe
    import dsp_pkg::*;
#(
    parameter int WIDTH = D_W,
    parameter int DEPTH = 1
) (
    input  logic         CLK,
    input  logic         RST,
    opreg_pipe_if.slave  bus
);

    logic [WIDTH-1:0] x_p0;

    assign x_p0 = (bus.SEL_CASC == SEL_CASCADE) ? bus.DCIN : bus.D;

    if (DEPTH < 0 || DEPTH > OPREG_DEPTH_MAX || WIDTH < 1 || WIDTH > C_W) begin : g_bad_param
        $error("opreg_pipe: unsupported WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
    end

    if (DEPTH == 0) begin : g_bypass
        // No state at all: clock, reset and enable are intentionally ignored.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, CLK, RST, bus.CE};

        assign bus.Q     = x_p0;
        assign bus.DCOUT = x_p0;
        assign bus.VALID = 1'b1;
    end else begin : g_pipe
        localparam int FILL_W = $clog2(DEPTH + 1);
        localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

        logic [WIDTH-1:0]  stage_p [DEPTH+1];
        logic [FILL_W-1:0] fill_p;

        function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] f);
            return (f == FILL_FULL) ? f : f + 1'b1;
        endfunction

        assign stage_p[0] = x_p0;

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            opreg_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .CLK (CLK),
                .RST (RST),
                .CE  (bus.CE),
                .D   (stage_p[i]),
                .Q   (stage_p[i+1])
            );
        end

        // Fill counter advances with the data and saturates, so VALID never falls back on wrap.
        always_ff @(posedge CLK) begin
            if (RST) begin
                fill_p <= '0;
            end else if (bus.CE) begin
                fill_p <= fill_sat_inc(fill_p);
            end
        end

        assign bus.Q     = stage_p[DEPTH];
        assign bus.DCOUT = stage_p[DEPTH];
        assign bus.VALID = (fill_p == FILL_FULL);
    end

endmodule

// File: doc/opreg_pipe.md
# opreg_pipe

Parametrised operand input pipeline for the DSP48A1-style datapath. It supersedes the fixed single-stage B/A/D input registers with one block that covers all of them.
- Configurable width and depth (0 = bypass), with runtime selection between direct and cascade input.
- Exposes a cascade output for chaining into a neighbouring slice.
- Tracks pipeline fill, so downstream logic knows when the output holds real data rather than reset zeros.

## Interface
- WIDTH, 18, operand width in bits (1..48).
- DEPTH, 1, number of register stages (0..4); 0 makes the block purely combinational.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high; clears every stage and the fill counter.
- CE  input  1  clock enable; when high, all stages advance together.
- SEL_CASC  input  1  input select: 0 = D, 1 = DCIN.
- D  input  WIDTH  direct operand input.
- DCIN  input  WIDTH  cascade operand input from the neighbouring slice.
- Q  output  WIDTH  pipelined operand (last stage, or the selected input when DEPTH=0).
- DCOUT  output  WIDTH  cascade output; always equal to Q.
- VALID  output  1  high once DEPTH CE-qualified cycles have elapsed since reset.

## Operation
- Selected input X = SEL_CASC ? DCIN : D.
  - SEL_CASC is sampled with X on every CE edge.
  - Switching SEL_CASC mid-stream is legal; data already in flight is unaffected.
- DEPTH=0:
  - Q = DCOUT = X combinationally; VALID tied to 1.
  - RST and CE have no effect.
  - No flops are inferred.
- DEPTH>=1:
  - Stages S[0..DEPTH-1], each WIDTH bits; Q = S[DEPTH-1].
  - On a rising edge, if RST: all S[i] <= 0 and FILL <= 0.
  - Else if CE:
    - S[0] <= X.
    - S[i] <= S[i-1] for i >= 1.
    - FILL <= min(FILL+1, DEPTH).
  - Else: all state holds.
- RST has priority over CE; a reset while CE=1 still clears everything.
- FILL counter is clog2(DEPTH+1) bits and saturates at DEPTH; it never wraps.
- VALID = (FILL == DEPTH).
- Reset mid-stream discards all in-flight data. VALID drops on the edge that samples RST and stays low until DEPTH further CE cycles.
- No arithmetic is performed; data passes bit-exact, with no sign extension or truncation.
- Out-of-range DEPTH (>4) or WIDTH (<1 or >48) is an elaboration error.

## Timing
- Latency: a value of X sampled on CE edge n appears on Q after edge n+DEPTH-1, counting only CE-high edges.
  - DEPTH=1: Q updates one clock after the sampling edge, matching the legacy input register.
- With CE held high, throughput is one operand per clock and the latency is exactly DEPTH clocks.
- Reset values (DEPTH>=1): Q = 0, DCOUT = 0, VALID = 0. All three are valid in the cycle after the RST edge.
- Q, DCOUT and VALID are driven directly from flops when DEPTH>=1; there is no combinational path from D, DCIN or SEL_CASC.
- When DEPTH=0 there is a combinational path from D/DCIN/SEL_CASC to Q/DCOUT only.

## Structure
- Shared package dsp_pkg holds:
  - OPREG_DEPTH_MAX = 4.
  - Default widths A_W = 18, B_W = 18, D_W = 18, C_W = 48.
  - Input-select encoding constants SEL_DIRECT = 0 and SEL_CASCADE = 1.
- Sub-module opreg_stage: one WIDTH-bit register with synchronous active-high reset and CE.
  - Instantiated DEPTH times by a generate loop.
  - The fill counter and input mux live in the top level.
- Existing A, B and D input register instances migrate to opreg_pipe with DEPTH=1, SEL_CASC=0.

## Test plan
- DEPTH=2, WIDTH=18, CE=1, SEL_CASC=0; RST for 1 cycle, then D=0x00001, 0x00002, 0x00003 on consecutive clocks.
  - Q reads 0, 0, 0x00001, 0x00002, 0x00003 (2-cycle latency).
  - VALID rises on the 2nd clock after RST deasserts.
- DEPTH=3, streaming 0x10, 0x11, 0x12 with CE pattern 1,0,1,1,0,1.
  - Q advances only on CE-high edges; Q=0x10 appears after the third CE-high edge.
  - FILL holds on CE=0; VALID asserts after 3 enabled edges.
- DEPTH=2, stream full (VALID=1); assert RST together with CE=1 for one clock.
  - Q=0 and VALID=0 the next cycle.
  - New data 0x3FFFF reaches Q after 2 further CE edges; VALID re-asserts at the same edge.
- DEPTH=1, DCIN=0x2AAAA, D=0x15555; toggle SEL_CASC 0,1,0 across three clocks.
  - Q = 0x15555, 0x2AAAA, 0x15555, each one clock later.
  - DCOUT equals Q on every cycle.
- DEPTH=0, WIDTH=48, D=0xFFFF_FFFF_FFFF with RST=1 and CE=0.
  - Q = 0xFFFF_FFFF_FFFF in the same cycle; VALID=1; reset is ignored.
- DEPTH=4, CE=1 for 100 cycles with random D.
  - Q(t) = D(t-4) bit-exact throughout.
  - FILL saturates at 4 with no wrap; VALID stays high.
